// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the pipeline skid stage: state encoding, default widths,
// the entry record and a state-to-occupancy helper.
package pipe_stage_skid_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NWORDS_DEF = 5;
  localparam int EXC_W_DEF  = 7;
  localparam int WBA_W      = 5;
  localparam int PC_W       = 32;

  // Encoding chosen so the state value equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // One pipeline entry at default widths; field order matches the flat
  // {data, wba, pc, exc} packing used inside the stage.
  typedef struct packed {
    logic [NWORDS_DEF*DATA_W_DEF-1:0] data;
    logic [WBA_W-1:0]                 wba;
    logic [PC_W-1:0]                  pc;
    logic [EXC_W_DEF-1:0]             exc;
  } entry_t;

  function automatic logic [1:0] occ_of(state_t s);
    case (s)
      ST_MAIN: occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between an upstream producer, the stage and downstream.
// Valid/ready: a word moves on a rising edge where valid and ready are both 1;
// valid and payload must hold until that edge, ready may change any cycle.
interface pipe_stage_skid_if
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NWORDS = NWORDS_DEF,
  parameter int EXC_W  = EXC_W_DEF
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [NWORDS*DATA_W-1:0] in_data;
  logic [WBA_W-1:0]         in_wba;
  logic [PC_W-1:0]          in_pc;
  logic [EXC_W-1:0]         in_exc;
  logic                     out_valid;
  logic                     out_ready;
  logic [NWORDS*DATA_W-1:0] out_data;
  logic [WBA_W-1:0]         out_wba;
  logic [PC_W-1:0]          out_pc;
  logic [EXC_W-1:0]         out_exc;
  logic                     out_exc_any;
  logic [1:0]               occupancy;
  state_t                   dbg_state;

  modport master (
    output flush, in_valid, in_data, in_wba, in_pc, in_exc, out_ready,
    input  in_ready, out_valid, out_data, out_wba, out_pc, out_exc,
           out_exc_any, occupancy, dbg_state
  );

  modport slave (
    input  flush, in_valid, in_data, in_wba, in_pc, in_exc, out_ready,
    output in_ready, out_valid, out_data, out_wba, out_pc, out_exc,
           out_exc_any, occupancy, dbg_state
  );
endinterface

// File: rtl/pipe_entry_reg.sv
// Clearable, load-enabled register holding one flattened pipeline entry.
module pipe_entry_reg #(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Clear wins over load so a flush always leaves the register zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// One-cycle pipeline stage. SKID=1 keeps a second entry so in_ready can be a
// flop; SKID=0 is a single register whose in_ready looks through out_ready.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NWORDS = NWORDS_DEF,
  parameter int EXC_W  = EXC_W_DEF,
  parameter int SKID   = 1
)(
  input  logic              clk,
  input  logic              rst,
  pipe_stage_skid_if.slave  bus
);
  localparam int DW    = NWORDS*DATA_W;
  localparam int ENT_W = DW + WBA_W + PC_W + EXC_W;

  state_t           state_q, state_d;
  logic             main_ld, main_clr, skid_ld, skid_clr, main_from_skid;
  logic [ENT_W-1:0] in_ent, main_d, main_q, skid_q;
  logic             in_ready_c, out_valid_c, in_fire, out_fire;

  assign in_ent      = {bus.in_data, bus.in_wba, bus.in_pc, bus.in_exc};
  assign out_valid_c = (state_q != ST_EMPTY);
  assign in_fire     = bus.in_valid & in_ready_c;
  assign out_fire    = out_valid_c & bus.out_ready;
  assign main_d      = main_from_skid ? skid_q : in_ent;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next state and register enables; flush overrides every transfer.
  // With SKID=0, MAIN never sees an accept without a departure, so FULL is unreachable.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
    if (bus.flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin
          state_d = ST_MAIN;
          main_ld = 1'b1;
        end
        ST_MAIN: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (out_fire) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_FULL: if (out_fire) begin
          state_d        = ST_MAIN;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Main entry is cleared whenever the stage empties, so outputs read zero when idle.
  pipe_entry_reg #(.W(ENT_W)) u_main (
    .clk (clk),
    .rst (rst),
    .clr (main_clr),
    .ld  (main_ld),
    .d   (main_d),
    .q   (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      // Registered ready: decoded from the next state, never from out_ready.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= (state_d != ST_FULL);
      end
      assign in_ready_c = in_ready_q;

      pipe_entry_reg #(.W(ENT_W)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (skid_clr),
        .ld  (skid_ld),
        .d   (in_ent),
        .q   (skid_q)
      );
    end else begin : g_single
      assign in_ready_c = (state_q != ST_MAIN) | bus.out_ready;
      assign skid_q     = '0;
    end
  endgenerate

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_data    = main_q[ENT_W-1 -: DW];
  assign bus.out_wba     = main_q[WBA_W+PC_W+EXC_W-1 -: WBA_W];
  assign bus.out_pc      = main_q[PC_W+EXC_W-1 -: PC_W];
  assign bus.out_exc     = main_q[EXC_W-1:0];
  assign bus.out_exc_any = out_valid_c & (|main_q[EXC_W-1:0]);
  assign bus.occupancy   = occ_of(state_q);
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1 and a SKID=0 instance share stimulus,
// each with its own expected-entry queue.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int DATA_W = 32;
  localparam int NWORDS = 5;
  localparam int EXC_W  = 7;
  localparam int ENT_W  = $bits(entry_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic   iv = 1'b0, ordy = 1'b0, fl = 1'b0;
  entry_t cur = '0;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .NWORDS(NWORDS), .EXC_W(EXC_W)) b1 ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .NWORDS(NWORDS), .EXC_W(EXC_W)) b0 ();

  assign b1.flush = fl;  assign b1.in_valid = iv;  assign b1.out_ready = ordy;
  assign b1.in_data = cur.data;  assign b1.in_wba = cur.wba;
  assign b1.in_pc = cur.pc;  assign b1.in_exc = cur.exc;
  assign b0.flush = fl;  assign b0.in_valid = iv;  assign b0.out_ready = ordy;
  assign b0.in_data = cur.data;  assign b0.in_wba = cur.wba;
  assign b0.in_pc = cur.pc;  assign b0.in_exc = cur.exc;

  pipe_stage_skid #(.DATA_W(DATA_W), .NWORDS(NWORDS), .EXC_W(EXC_W), .SKID(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  pipe_stage_skid #(.DATA_W(DATA_W), .NWORDS(NWORDS), .EXC_W(EXC_W), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));

  // ---------------- scoreboard ----------------
  logic [ENT_W-1:0] q1[$];
  logic [ENT_W-1:0] q0[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic entry_t mk_entry(logic [7:0] tag, logic [6:0] exc);
    entry_t e;
    for (int i = 0; i < NWORDS; i++)
      e.data[i*DATA_W +: DATA_W] = {24'h0, tag} + 32'(i) * 32'h100;
    e.wba = tag[4:0];
    e.pc  = 32'h8000_0000 | {24'h0, tag};
    e.exc = exc;
    return e;
  endfunction

  // Compare each instance against the head of its queue after an edge.
  task automatic post_check();
    logic [ENT_W-1:0] ent1, ent0;
    entry_t e;
    ent1 = {b1.out_data, b1.out_wba, b1.out_pc, b1.out_exc};
    ent0 = {b0.out_data, b0.out_wba, b0.out_pc, b0.out_exc};
    chk("occ1", b1.occupancy, q1.size());
    chk("in_ready1", b1.in_ready, q1.size() < 2);
    chk("out_valid1", b1.out_valid, q1.size() != 0);
    if (q1.size() != 0) begin
      e = entry_t'(q1[0]);
      chk("entry1", ent1, q1[0]);
      chk("exc_any1", b1.out_exc_any, |e.exc);
    end else begin
      chk("zero1", ent1, 0);
      chk("exc_any1_idle", b1.out_exc_any, 0);
    end
    chk("occ0", b0.occupancy, q0.size());
    chk("out_valid0", b0.out_valid, q0.size() != 0);
    if (q0.size() != 0) begin
      e = entry_t'(q0[0]);
      chk("entry0", ent0, q0[0]);
      chk("exc_any0", b0.out_exc_any, |e.exc);
    end else begin
      chk("zero0", ent0, 0);
    end
  endtask

  // Driver: inputs already set; run one edge, update the queues, check.
  task automatic step();
    bit f1_in, f1_out, f0_in, f0_out;
    @(negedge clk);
    chk("in_ready0", b0.in_ready, (q0.size() == 0) || ordy);
    f1_in  = iv && (q1.size() < 2);
    f1_out = ordy && (q1.size() != 0);
    f0_in  = iv && ((q0.size() == 0) || ordy);
    f0_out = ordy && (q0.size() != 0);
    @(posedge clk);
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (f1_out) void'(q1.pop_front());
      if (f1_in)  q1.push_back(cur);
      if (f0_out) void'(q0.pop_front());
      if (f0_in)  q0.push_back(cur);
    end
    #1;
    post_check();
  endtask

  // ---------------- vector table (checks on the SKID=1 instance) ----------------
  typedef struct {
    logic       iv, ordy, fl;
    logic [7:0] tag;
    logic [6:0] exc;
    logic [1:0] occ;
    logic       ir, ov, any;
    logic [7:0] w0;
  } vec_t;

  function automatic vec_t mkv(logic v_iv, logic v_ordy, logic v_fl, logic [7:0] tag,
                               logic [6:0] exc, logic [1:0] occ, logic ir, logic ov,
                               logic any, logic [7:0] w0);
    vec_t v;
    v.iv = v_iv; v.ordy = v_ordy; v.fl = v_fl; v.tag = tag; v.exc = exc;
    v.occ = occ; v.ir = ir; v.ov = ov; v.any = any; v.w0 = w0;
    return v;
  endfunction

  vec_t vecs[20];
  logic [7:0] tag_ctr;

  initial begin
    // streaming 0x11..0x15 with downstream always ready
    vecs[0]  = mkv(1, 1, 0, 8'h11, 7'h0, 2'd1, 1, 1, 0, 8'h11);
    vecs[1]  = mkv(1, 1, 0, 8'h12, 7'h0, 2'd1, 1, 1, 0, 8'h12);
    vecs[2]  = mkv(1, 1, 0, 8'h13, 7'h0, 2'd1, 1, 1, 0, 8'h13);
    vecs[3]  = mkv(1, 1, 0, 8'h14, 7'h0, 2'd1, 1, 1, 0, 8'h14);
    vecs[4]  = mkv(1, 1, 0, 8'h15, 7'h0, 2'd1, 1, 1, 0, 8'h15);
    vecs[5]  = mkv(0, 1, 0, 8'h00, 7'h0, 2'd0, 1, 0, 0, 8'h00);
    // stall fills the skid, an extra offer in FULL is ignored, then drain in order
    vecs[6]  = mkv(1, 0, 0, 8'h0A, 7'h0, 2'd1, 1, 1, 0, 8'h0A);
    vecs[7]  = mkv(1, 0, 0, 8'h0B, 7'h0, 2'd2, 0, 1, 0, 8'h0A);
    vecs[8]  = mkv(1, 0, 0, 8'hEE, 7'h0, 2'd2, 0, 1, 0, 8'h0A);
    vecs[9]  = mkv(0, 1, 0, 8'h00, 7'h0, 2'd1, 1, 1, 0, 8'h0B);
    vecs[10] = mkv(0, 1, 0, 8'h00, 7'h0, 2'd0, 1, 0, 0, 8'h00);
    // flush while FULL with a new offer
    vecs[11] = mkv(1, 0, 0, 8'h0A, 7'h0, 2'd1, 1, 1, 0, 8'h0A);
    vecs[12] = mkv(1, 0, 0, 8'h0B, 7'h0, 2'd2, 0, 1, 0, 8'h0A);
    vecs[13] = mkv(1, 0, 1, 8'h0C, 7'h0, 2'd0, 1, 0, 0, 8'h00);
    vecs[14] = mkv(0, 1, 0, 8'h00, 7'h0, 2'd0, 1, 0, 0, 8'h00);
    // exception flag follows the presented entry
    vecs[15] = mkv(1, 0, 0, 8'h21, 7'h04, 2'd1, 1, 1, 1, 8'h21);
    vecs[16] = mkv(0, 0, 0, 8'h00, 7'h0, 2'd1, 1, 1, 1, 8'h21);
    vecs[17] = mkv(0, 1, 0, 8'h00, 7'h0, 2'd0, 1, 0, 0, 8'h00);
    // single entry passes through with one-cycle latency
    vecs[18] = mkv(1, 1, 0, 8'h5A, 7'h0, 2'd1, 1, 1, 0, 8'h5A);
    vecs[19] = mkv(0, 1, 0, 8'h00, 7'h0, 2'd0, 1, 0, 0, 8'h00);

    // reset state
    #7;
    chk("rst_out_valid1", b1.out_valid, 0);
    chk("rst_occ1", b1.occupancy, 0);
    chk("rst_in_ready1", b1.in_ready, 1);
    chk("rst_payload1", {b1.out_data, b1.out_wba, b1.out_pc, b1.out_exc}, 0);
    chk("rst_out_valid0", b0.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      iv = vecs[i].iv; ordy = vecs[i].ordy; fl = vecs[i].fl;
      cur = mk_entry(vecs[i].tag, vecs[i].exc);
      step();
      chk($sformatf("v%0d_occ", i), b1.occupancy, vecs[i].occ);
      chk($sformatf("v%0d_in_ready", i), b1.in_ready, vecs[i].ir);
      chk($sformatf("v%0d_out_valid", i), b1.out_valid, vecs[i].ov);
      chk($sformatf("v%0d_exc_any", i), b1.out_exc_any, vecs[i].any);
      chk($sformatf("v%0d_word0", i), b1.out_data[7:0], vecs[i].w0);
    end
    fl = 1'b0;

    // single-register mode: ready looks through out_ready in the same cycle
    iv = 1; ordy = 0; cur = mk_entry(8'h31, 7'h0);
    step();
    cur = mk_entry(8'h32, 7'h0);
    #1;
    chk("s0_ready_stalled", b0.in_ready, 0);
    ordy = 1;
    #1;
    chk("s0_ready_through", b0.in_ready, 1);
    step();
    chk("s0_replacement", b0.out_data[7:0], 8'h32);
    iv = 0;
    step();
    step();

    // asynchronous reset between edges while FULL
    iv = 1; ordy = 0; cur = mk_entry(8'h41, 7'h0);
    step();
    cur = mk_entry(8'h42, 7'h3);
    step();
    chk("pre_rst_occ1", b1.occupancy, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid1", b1.out_valid, 0);
    chk("arst_occ1", b1.occupancy, 0);
    chk("arst_in_ready1", b1.in_ready, 1);
    chk("arst_payload1", {b1.out_data, b1.out_wba, b1.out_pc, b1.out_exc}, 0);
    chk("arst_out_valid0", b0.out_valid, 0);
    q1.delete();
    q0.delete();
    #1;
    rst = 1'b0;
    iv = 0; ordy = 1;
    step();
    step();

    // randomized traffic with occasional flushes
    tag_ctr = 8'h60;
    for (int n = 0; n < 300; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      cur  = mk_entry(tag_ctr, ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'h0);
      tag_ctr = tag_ctr + 8'h1;
      step();
    end

    iv = 0; fl = 0; ordy = 1;
    for (int n = 0; n < 3; n++) step();
    chk("drain1", q1.size(), 0);
    chk("drain0", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each payload word.
REQ-002 SHALL have parameter NWORDS, default 5, payload words per entry (instr, rt, alu, ext, pc8).
REQ-003 SHALL have parameter EXC_W, default 7, exception-vector width.
REQ-004 SHALL have parameter SKID, default 1; 1 = two-entry skid stage, 0 = single-register stage.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 flush  input  1  synchronous kill of every held entry.
REQ-008 in_valid  input  1  upstream entry offered.
REQ-009 in_ready  output  1  stage accepts the offered entry this cycle.
REQ-010 in_data  input  NWORDS*DATA_W  payload.
REQ-011 in_wba  input  5  writeback register address.
REQ-012 in_pc  input  32  debug PC.
REQ-013 in_exc  input  EXC_W  exception vector accumulated upstream.
REQ-014 out_valid  output  1  entry presented downstream.
REQ-015 out_ready  input  1  downstream accepts the presented entry.
REQ-016 out_data, out_wba, out_pc, out_exc  output  widths as inputs  presented entry.
REQ-017 out_exc_any  output  1  out_valid AND any out_exc bit set.
REQ-018 occupancy  output  2  entries held (0..2; max 1 when SKID=0).

Function
REQ-019 Transfer in SHALL occur on a rising edge where in_valid and in_ready are both 1; transfer out where out_valid and out_ready are both 1.
REQ-020 Latency SHALL be one cycle: an entry accepted at edge N, into an empty stage, is presented from after edge N.
REQ-021 Entries SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-022 SKID=1: states EMPTY (0 held), MAIN (1), FULL (2, main + skid); in_ready SHALL equal NOT FULL and SHALL be a register output with no combinational path from out_ready.
REQ-023 SKID=1 transitions: EMPTY+in -> MAIN; MAIN+in+out -> MAIN (main replaced); MAIN+in, no out -> FULL (new entry to skid); MAIN+out, no in -> EMPTY; FULL+out -> MAIN (skid moves to main); FULL, no out -> FULL.
REQ-024 Sustained in_valid=1, out_ready=1 SHALL give one transfer per cycle in both modes.
REQ-025 SKID=0: in_ready SHALL equal (NOT out_valid) OR out_ready (combinational), occupancy max 1.
REQ-026 When out_valid=0, out_data, out_wba, out_pc and out_exc SHALL all be zero.
REQ-027 flush SHALL have priority over every transfer: after the flush edge the stage is EMPTY, payload zero, in_ready=1; an entry offered in the flush cycle is discarded.
REQ-028 Simultaneous in and out transfer in FULL cannot occur (in_ready=0); offers in FULL SHALL be ignored.
REQ-029 occupancy SHALL equal the held-entry count after each edge.

Reset
REQ-030 rst=1 SHALL asynchronously force EMPTY, all output payload fields 0, out_valid=0, occupancy=0, in_ready=1 (SKID=1).
REQ-031 Reset asserted mid-transfer SHALL discard all held entries; no entry presented until a new accepted transfer after rst deasserts.

Structure
REQ-032 Shared package SHALL hold the state encoding (EMPTY, MAIN, FULL), EXC_W default and the entry record type (data, wba, pc, exc).
REQ-033 One sub-module, pipe_entry_reg (clearable, load-enabled entry register), SHALL be instantiated for main and, when SKID=1, for skid.

Verification
REQ-034 SKID=1, in_valid=1 data 0x11..0x15 over 5 cycles, out_ready=1 -> outputs 0x11..0x15 on consecutive cycles, occupancy stays 1.
REQ-035 SKID=1, out_ready=0 with in_valid=1 data 0xA, 0xB -> occupancy 2, in_ready=0 after edge 2; out_ready=1 -> 0xA then 0xB, in_ready returns 1.
REQ-036 FULL, flush=1 with in_valid=1 data 0xC -> next cycle out_valid=0, all outputs 0, 0xC never presented.
REQ-037 in_exc=7'b0000100 accepted -> out_exc_any=1 while presented; out_valid=0 -> out_exc_any=0.
REQ-038 SKID=0, out_ready=0 with entry held -> in_ready=0; out_ready=1 same cycle -> in_ready=1, replacement presented next cycle.
REQ-039 rst pulse between edges while FULL -> immediate out_valid=0, occupancy 0, outputs 0.
